// File: rtl/draw_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// draw_pkg : draw command codes and scheduler state encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
package draw_pkg;

    localparam int CMD_W = 5;

    localparam logic [CMD_W-1:0] BACKGROUND   = 5'h13;
    localparam logic [CMD_W-1:0] PLAY_CLEAR   = 5'h14;
    localparam logic [CMD_W-1:0] FINE_LINE1   = 5'h17;
    localparam logic [CMD_W-1:0] PERFECT_LINE = 5'h19;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLR_ISSUE = 3'd1,
        ST_CLR_WAIT  = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT      = 3'd4
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first set req at or above rr_ptr
// Revision   : 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [IDX_W:0] idx_v;

    // Walk from the farthest offset down so the nearest set request is written last.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx_v  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_v = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (idx_v >= (IDX_W + 1)'(NUM_REQ)) begin
                idx_v = idx_v - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[idx_v[IDX_W-1:0]]) begin
                winner = idx_v[IDX_W-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/draw_cmd_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// draw_cmd_scheduler : shares the draw datapath among requesters, one frame clear per tick
// Revision           : 1.0
// ---------------------------------------------------------------------------
module draw_cmd_scheduler
    import draw_pkg::*;
#(
    parameter int               NUM_REQ     = 4,
    parameter int               CMD_W       = draw_pkg::CMD_W,
    parameter logic [CMD_W-1:0] CLEAR_CMD   = CMD_W'(BACKGROUND),
    parameter int               TIMEOUT_CYC = 32768
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
    output logic [NUM_REQ-1:0]       grant,
    output logic [CMD_W-1:0]         cmd,
    output logic                     cmd_start,
    input  logic                     cmd_done,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     frame_overrun
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    sched_state_e        state_q, state_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic                cmd_start_q, cmd_start_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic                frame_overrun_q, frame_overrun_d;
    logic                clear_pending_q, clear_pending_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic [IDX_W-1:0]    arb_winner;
    logic                arb_any;
    logic [CMD_W-1:0]    req_cmd_arr [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (arb_winner),
        .any    (arb_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_cmd_arr[i] = req_cmd[i*CMD_W +: CMD_W];
        end
    end

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        cmd_start_d     = 1'b0;
        grant_d         = '0;
        timeout_err_d   = timeout_err_q;
        frame_overrun_d = frame_overrun_q;
        clear_pending_d = clear_pending_q;
        rr_ptr_d        = rr_ptr_q;
        winner_d        = winner_q;
        wait_cnt_d      = wait_cnt_q;

        if (state_q == ST_CLR_ISSUE) begin
            clear_pending_d = 1'b0;
        end
        // A new tick re-arms the clear even while the previous one is being issued.
        if (frame_tick) begin
            clear_pending_d = 1'b1;
            if (clear_pending_q || state_q == ST_CLR_ISSUE || state_q == ST_CLR_WAIT) begin
                frame_overrun_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_pending_q || frame_tick) begin
                    state_d     = ST_CLR_ISSUE;
                    cmd_d       = CLEAR_CMD;
                    cmd_start_d = 1'b1;
                end else if (arb_any) begin
                    state_d              = ST_ISSUE;
                    cmd_d                = req_cmd_arr[arb_winner];
                    cmd_start_d          = 1'b1;
                    grant_d[arb_winner]  = 1'b1;
                    winner_d             = arb_winner;
                end
            end
            ST_CLR_ISSUE: begin
                state_d    = ST_CLR_WAIT;
                wait_cnt_d = '0;
            end
            ST_ISSUE: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_CLR_WAIT, ST_WAIT: begin
                if (cmd_done || wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                    if (!cmd_done) begin
                        timeout_err_d = 1'b1;
                    end
                    if (state_q == ST_WAIT) begin
                        rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            cmd_q           <= '0;
            cmd_start_q     <= 1'b0;
            grant_q         <= '0;
            busy_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
            frame_overrun_q <= 1'b0;
            clear_pending_q <= 1'b0;
            rr_ptr_q        <= '0;
            winner_q        <= '0;
            wait_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            cmd_start_q     <= cmd_start_d;
            grant_q         <= grant_d;
            busy_q          <= busy_d;
            timeout_err_q   <= timeout_err_d;
            frame_overrun_q <= frame_overrun_d;
            clear_pending_q <= clear_pending_d;
            rr_ptr_q        <= rr_ptr_d;
            winner_q        <= winner_d;
            wait_cnt_q      <= wait_cnt_d;
        end
    end

    assign grant         = grant_q;
    assign cmd           = cmd_q;
    assign cmd_start     = cmd_start_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;
    assign frame_overrun = frame_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_cmd_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_draw_cmd_scheduler : scoreboard bench for draw_cmd_scheduler
// Revision              : 1.0
// ---------------------------------------------------------------------------
module tb_draw_cmd_scheduler;

    localparam int TIMEOUT = 32768;

    typedef struct packed {
        logic [4:0] cmd;
        logic [3:0] grant;
    } exp_t;

    logic        CLK;
    logic        reset;
    logic        frame_tick;
    logic [3:0]  req;
    logic [19:0] req_cmd;
    logic [3:0]  grant;
    logic [4:0]  cmd;
    logic        cmd_start;
    logic        cmd_done;
    logic        busy;
    logic        timeout_err;
    logic        frame_overrun;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   resp_cnt = 0;
    int   resp_dly = 5;
    bit   resp_en  = 1'b1;
    bit   b2b_chk  = 1'b0;
    bit   have_done = 1'b0;
    int   last_done_cyc = 0;

    draw_cmd_scheduler u_dut (
        .CLK           (CLK),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .req           (req),
        .req_cmd       (req_cmd),
        .grant         (grant),
        .cmd           (cmd),
        .cmd_start     (cmd_start),
        .cmd_done      (cmd_done),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .frame_overrun (frame_overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: observe the edge result, run the datapath responder and the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        cmd_done = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                cmd_done      = 1'b1;
                last_done_cyc = cyc;
                have_done     = 1'b1;
            end
        end
        if (cmd_start) begin
            if (resp_en) resp_cnt = resp_dly;
            if (b2b_chk && have_done) check("b2b_gap", cyc - last_done_cyc, 2);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_cmd", {27'd0, cmd}, {27'd0, e.cmd});
                check("sb_grant", {28'd0, grant}, {28'd0, e.grant});
            end else begin
                check("sb_unexpected_start", 1, 0);
            end
        end else if (grant != 4'b0000) begin
            check("grant_no_start", {28'd0, grant}, 0);
        end
    endtask

    task automatic push(input logic [4:0] c, input logic [3:0] g);
        exp_t e;
        e.cmd   = c;
        e.grant = g;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        req        = 4'b0000;
        frame_tick = 1'b0;
        resp_cnt   = 0;
        cmd_done   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int starts;
        int w;
        reset      = 1'b0;
        frame_tick = 1'b0;
        req        = 4'b0000;
        cmd_done   = 1'b0;
        req_cmd    = {5'h12, 5'h02, 5'h11, 5'h10};

        // Reset state and quiet idle
        do_reset();
        check("rst_grant", {28'd0, grant}, 0);
        check("rst_cmd", {27'd0, cmd}, 0);
        check("rst_start", {31'd0, cmd_start}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_timeout", {31'd0, timeout_err}, 0);
        check("rst_overrun", {31'd0, frame_overrun}, 0);
        starts = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cmd_start || busy) starts++;
        end
        check("idle_quiet", starts, 0);

        // Single request, latency and completion
        resp_dly = 9;
        push(5'h02, 4'b0100);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        check("t2_grant", {28'd0, grant}, 32'h4);
        check("t2_start", {31'd0, cmd_start}, 1);
        check("t2_cmd", {27'd0, cmd}, 32'h02);
        for (int i = 0; i < 9; i++) tick();
        check("t2_busy_at_done", {31'd0, busy}, 1);
        tick();
        check("t2_busy_after", {31'd0, busy}, 0);

        // Round robin under full load
        do_reset();
        resp_dly  = 5;
        have_done = 1'b0;
        b2b_chk   = 1'b1;
        push(5'h10, 4'b0001);
        push(5'h11, 4'b0010);
        push(5'h02, 4'b0100);
        push(5'h12, 4'b1000);
        push(5'h10, 4'b0001);
        req    = 4'b1111;
        starts = 0;
        for (int i = 0; i < 200 && starts < 5; i++) begin
            tick();
            if (cmd_start) starts++;
        end
        req = 4'b0000;
        check("t3_starts", starts, 5);
        wait_idle(50);
        b2b_chk = 1'b0;

        // Clear beats a simultaneous request
        do_reset();
        push(5'h13, 4'b0000);
        push(5'h10, 4'b0001);
        frame_tick = 1'b1;
        req        = 4'b0001;
        tick();
        frame_tick = 1'b0;
        starts = 1;
        for (int i = 0; i < 50 && starts < 2; i++) begin
            tick();
            if (cmd_start) starts++;
        end
        req = 4'b0000;
        check("t4_starts", starts, 2);
        wait_idle(50);

        // Second tick during a clear flags overrun and queues another clear
        push(5'h13, 4'b0000);
        push(5'h13, 4'b0000);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        check("t4_no_overrun", {31'd0, frame_overrun}, 0);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        check("t4_overrun", {31'd0, frame_overrun}, 1);
        wait_idle(50);
        wait_idle(50);

        // Timeout with no done
        do_reset();
        resp_en = 1'b0;
        push(5'h11, 4'b0010);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        check("t5_start", {31'd0, cmd_start}, 1);
        check("t5_no_timeout_yet", {31'd0, timeout_err}, 0);
        w = cyc + 1;
        for (int i = 0; i < TIMEOUT + 20; i++) begin
            tick();
            if (!busy) break;
        end
        check("t5_timeout_cycles", cyc - w, TIMEOUT);
        check("t5_timeout_err", {31'd0, timeout_err}, 1);
        resp_en  = 1'b1;
        resp_dly = 3;
        push(5'h12, 4'b1000);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        check("t5_next_grant", {28'd0, grant}, 32'h8);
        wait_idle(50);

        // Reset in the middle of WAIT
        do_reset();
        resp_en = 1'b0;
        push(5'h10, 4'b0001);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        frame_tick = 1'b1;
        tick();
        tick();
        frame_tick = 1'b0;
        check("t6_overrun_pre", {31'd0, frame_overrun}, 1);
        check("t6_busy_pre", {31'd0, busy}, 1);
        reset = 1'b0;
        tick();
        check("t6_busy", {31'd0, busy}, 0);
        check("t6_grant", {28'd0, grant}, 0);
        check("t6_overrun", {31'd0, frame_overrun}, 0);
        check("t6_timeout", {31'd0, timeout_err}, 0);
        reset    = 1'b1;
        resp_en  = 1'b1;
        resp_dly = 9;
        push(5'h02, 4'b0100);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        check("t6_grant_after", {28'd0, grant}, 32'h4);
        check("t6_cmd_after", {27'd0, cmd}, 32'h02);
        wait_idle(50);

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
